// File: rtl/nanomamba_pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : nanomamba_pwr_pkg
// Brief  : State encodings, default widths and saturation limits shared by
//          the NanoMamba power sequencer.
// Rev    : 1.0
// ============================================================================
package nanomamba_pwr_pkg;

  localparam int unsigned c_NUM_EXP_DEF = 2;
  localparam int unsigned c_TIMER_W_DEF = 20;
  localparam int unsigned c_WAKE_W_DEF  = 8;
  localparam int unsigned c_GATE_W_DEF  = 8;

  localparam logic [7:0] c_OVR_SAT = 8'hFF;

  localparam logic [2:0] c_ST_DEEP_SLEEP = 3'd0;
  localparam logic [2:0] c_ST_WAKE       = 3'd1;
  localparam logic [2:0] c_ST_STFT       = 3'd2;
  localparam logic [2:0] c_ST_RAMP       = 3'd3;
  localparam logic [2:0] c_ST_COMPUTE    = 3'd4;
  localparam logic [2:0] c_ST_INTER      = 3'd5;
  localparam logic [2:0] c_ST_DONE       = 3'd6;

endpackage
`default_nettype wire

// File: rtl/nanomamba_pwr_seq_icg.sv
`default_nettype none
// ============================================================================
// Module : nanomamba_icg
// Brief  : Glitch-free clock gate; latch is transparent while clk is low.
// Rev    : 1.0
// ============================================================================
module nanomamba_icg (
  input  logic clk,
  input  logic en,
  output logic gclk
);

`ifdef FPGA_TARGET
  assign gclk = clk & en;
`else
  logic r_en_lat;

  always_latch begin
    if (!clk) r_en_lat <= en;
  end

  assign gclk = clk & r_en_lat;
`endif

endmodule
`default_nettype wire

// File: rtl/nanomamba_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module : nanomamba_pwr_seq
// Brief  : Power sequencer for the NanoMamba KWS core: wake, staggered domain
//          ramp, frame pacing with overrun detection, and clock gating.
// Rev    : 1.0
// ============================================================================
module nanomamba_pwr_seq
  import nanomamba_pwr_pkg::*;
#(
  parameter int unsigned NUM_EXP = c_NUM_EXP_DEF,
  parameter int unsigned TIMER_W = c_TIMER_W_DEF,
  parameter int unsigned WAKE_W  = c_WAKE_W_DEF,
  parameter int unsigned GATE_W  = c_GATE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ctrl_start,
  input  logic                      ctrl_stop,
  input  logic                      vad_trigger,
  input  logic                      frame_done,
  input  logic                      logits_valid,
  input  logic [NUM_EXP*GATE_W-1:0] gate_w,
  input  logic [GATE_W-1:0]         cfg_gate_thr,
  input  logic                      cfg_force_all,
  input  logic [TIMER_W-1:0]        cfg_frame_cycles,
  input  logic [WAKE_W-1:0]         cfg_wake_cycles,
  output logic                      status_busy,
  output logic                      status_done,
  output logic [2:0]                pwr_state,
  output logic [7:0]                overrun_cnt,
  output logic                      clk_en_stft,
  output logic                      clk_en_ssm,
  output logic [NUM_EXP-1:0]        clk_en_exp,
  output logic                      clk_stft,
  output logic                      clk_ssm,
  output logic [NUM_EXP-1:0]        clk_exp
);

  localparam logic [NUM_EXP-1:0] c_EXP_ONE  = NUM_EXP'(1);
  localparam logic [TIMER_W-1:0] c_TMR_ONE  = TIMER_W'(1);
  localparam logic [WAKE_W-1:0]  c_WAKE_ONE = WAKE_W'(1);

  logic [2:0]         r_state,      w_state_nxt;
  logic [WAKE_W-1:0]  r_wake_cnt,   w_wake_cnt_nxt;
  logic [TIMER_W-1:0] r_frame_tmr,  w_frame_tmr_nxt;
  logic [NUM_EXP-1:0] r_ramp_rem,   w_ramp_rem_nxt;
  logic               r_fd_pending, w_fd_pending_nxt;
  logic               r_done,       w_done_nxt;
  logic [7:0]         r_ovr_cnt,    w_ovr_cnt_nxt;
  logic               r_en_stft,    w_en_stft_nxt;
  logic               r_en_ssm,     w_en_ssm_nxt;
  logic [NUM_EXP-1:0] r_en_exp,     w_en_exp_nxt;

  logic [NUM_EXP-1:0] w_mask_raw;
  logic [NUM_EXP-1:0] w_mask;
  logic [NUM_EXP-1:0] w_ramp_low;
  logic               w_frame_end;
  logic               w_counting;

  for (genvar gi = 0; gi < NUM_EXP; gi++) begin : g_mask
    assign w_mask_raw[gi] = cfg_force_all | (gate_w[gi*GATE_W +: GATE_W] >= cfg_gate_thr);
  end

  // An empty mask would leave the router with no expert; power them all instead.
  assign w_mask      = (|w_mask_raw) ? w_mask_raw : '1;
  assign w_ramp_low  = r_ramp_rem & (~r_ramp_rem + c_EXP_ONE);
  assign w_frame_end = (r_frame_tmr >= (cfg_frame_cycles - c_TMR_ONE));
  assign w_counting  = (r_state == c_ST_STFT) || (r_state == c_ST_RAMP) ||
                       (r_state == c_ST_COMPUTE) || (r_state == c_ST_INTER);

  always_comb begin
    w_state_nxt      = r_state;
    w_wake_cnt_nxt   = r_wake_cnt;
    w_frame_tmr_nxt  = r_frame_tmr;
    w_ramp_rem_nxt   = r_ramp_rem;
    w_fd_pending_nxt = r_fd_pending;
    w_done_nxt       = r_done;
    w_ovr_cnt_nxt    = r_ovr_cnt;
    w_en_stft_nxt    = r_en_stft;
    w_en_ssm_nxt     = r_en_ssm;
    w_en_exp_nxt     = r_en_exp;

    case (r_state)
      c_ST_DEEP_SLEEP: begin
        w_en_stft_nxt = 1'b0;
        w_en_ssm_nxt  = 1'b0;
        w_en_exp_nxt  = '0;
        if (ctrl_start || vad_trigger) begin
          w_state_nxt    = c_ST_WAKE;
          w_wake_cnt_nxt = cfg_wake_cycles;
          w_done_nxt     = 1'b0;
          w_en_stft_nxt  = 1'b1;
        end
      end
      c_ST_WAKE: begin
        if (r_wake_cnt == '0) w_state_nxt = c_ST_STFT;
        else                  w_wake_cnt_nxt = r_wake_cnt - c_WAKE_ONE;
      end
      c_ST_STFT: begin
        if (frame_done) begin
          w_state_nxt    = c_ST_RAMP;
          w_ramp_rem_nxt = w_mask;
          w_en_ssm_nxt   = 1'b1;
        end
      end
      c_ST_RAMP: begin
        w_fd_pending_nxt = r_fd_pending | frame_done;
        // Lowest remaining bit each cycle gives the ascending, skip-free order.
        if (r_ramp_rem == '0) begin
          w_state_nxt = c_ST_COMPUTE;
        end else begin
          w_en_exp_nxt   = r_en_exp | w_ramp_low;
          w_ramp_rem_nxt = r_ramp_rem & ~w_ramp_low;
        end
      end
      c_ST_COMPUTE: begin
        w_fd_pending_nxt = 1'b0;
        if (logits_valid) begin
          w_state_nxt  = c_ST_DONE;
          w_done_nxt   = 1'b1;
          w_en_ssm_nxt = 1'b0;
          w_en_exp_nxt = '0;
        end else if (frame_done || r_fd_pending) begin
          w_en_ssm_nxt = 1'b0;
          w_en_exp_nxt = '0;
          if (w_frame_end) begin
            w_state_nxt   = c_ST_STFT;
            w_en_stft_nxt = 1'b1;
            w_ovr_cnt_nxt = (r_ovr_cnt == c_OVR_SAT) ? r_ovr_cnt : r_ovr_cnt + 8'd1;
          end else begin
            w_state_nxt   = c_ST_INTER;
            w_en_stft_nxt = 1'b0;
          end
        end
      end
      c_ST_INTER: begin
        if (w_frame_end) begin
          w_state_nxt   = c_ST_STFT;
          w_en_stft_nxt = 1'b1;
        end
      end
      c_ST_DONE: begin
        w_en_ssm_nxt = 1'b0;
        w_en_exp_nxt = '0;
        if (ctrl_start) begin
          w_state_nxt   = c_ST_STFT;
          w_done_nxt    = 1'b0;
          w_en_stft_nxt = 1'b1;
        end else begin
          w_state_nxt   = c_ST_DEEP_SLEEP;
          w_en_stft_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = c_ST_DEEP_SLEEP;
        w_en_stft_nxt = 1'b0;
        w_en_ssm_nxt  = 1'b0;
        w_en_exp_nxt  = '0;
      end
    endcase

    if (ctrl_stop) begin
      w_state_nxt      = c_ST_DEEP_SLEEP;
      w_fd_pending_nxt = 1'b0;
      w_en_stft_nxt    = 1'b0;
      w_en_ssm_nxt     = 1'b0;
      w_en_exp_nxt     = '0;
    end

    if ((w_state_nxt == c_ST_DEEP_SLEEP) ||
        ((w_state_nxt == c_ST_STFT) && (r_state != c_ST_STFT)))
      w_frame_tmr_nxt = '0;
    else if (w_counting)
      w_frame_tmr_nxt = r_frame_tmr + c_TMR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_DEEP_SLEEP;
      r_wake_cnt   <= '0;
      r_frame_tmr  <= '0;
      r_ramp_rem   <= '0;
      r_fd_pending <= 1'b0;
      r_done       <= 1'b0;
      r_ovr_cnt    <= '0;
      r_en_stft    <= 1'b0;
      r_en_ssm     <= 1'b0;
      r_en_exp     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wake_cnt   <= w_wake_cnt_nxt;
      r_frame_tmr  <= w_frame_tmr_nxt;
      r_ramp_rem   <= w_ramp_rem_nxt;
      r_fd_pending <= w_fd_pending_nxt;
      r_done       <= w_done_nxt;
      r_ovr_cnt    <= w_ovr_cnt_nxt;
      r_en_stft    <= w_en_stft_nxt;
      r_en_ssm     <= w_en_ssm_nxt;
      r_en_exp     <= w_en_exp_nxt;
    end
  end

  assign status_busy = (r_state != c_ST_DEEP_SLEEP) && (r_state != c_ST_DONE);
  assign status_done = r_done;
  assign pwr_state   = r_state;
  assign overrun_cnt = r_ovr_cnt;
  assign clk_en_stft = r_en_stft;
  assign clk_en_ssm  = r_en_ssm;
  assign clk_en_exp  = r_en_exp;

  logic [NUM_EXP+1:0] w_icg_en;
  logic [NUM_EXP+1:0] w_icg_clk;

  assign w_icg_en = {r_en_exp, r_en_ssm, r_en_stft};

  for (genvar gi = 0; gi < NUM_EXP + 2; gi++) begin : g_icg
    nanomamba_icg u_icg (
      .clk  (clk),
      .en   (w_icg_en[gi]),
      .gclk (w_icg_clk[gi])
    );
  end

  assign clk_stft = w_icg_clk[0];
  assign clk_ssm  = w_icg_clk[1];
  assign clk_exp  = w_icg_clk[NUM_EXP+1:2];

endmodule
`default_nettype wire

// File: tb/tb_nanomamba_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_nanomamba_pwr_seq
// Brief  : Self-checking bench for nanomamba_pwr_seq with four experts.
// Rev    : 1.0
// ============================================================================
module tb_nanomamba_pwr_seq;
  import nanomamba_pwr_pkg::*;

  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ctrl_start, ctrl_stop, vad_trigger, frame_done, logits_valid;
  logic [31:0]   gate_w;
  logic [7:0]    cfg_gate_thr;
  logic          cfg_force_all;
  logic [19:0]   cfg_frame_cycles;
  logic [7:0]    cfg_wake_cycles;
  logic          status_busy, status_done;
  logic [2:0]    pwr_state;
  logic [7:0]    overrun_cnt;
  logic          clk_en_stft, clk_en_ssm;
  logic [NE-1:0] clk_en_exp;
  logic          clk_stft, clk_ssm;
  logic [NE-1:0] clk_exp;

  typedef struct {
    logic [31:0] gw;
    logic [7:0]  thr;
    logic        force_all;
    logic [3:0]  mask;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    int         lat;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   tmr = 0;
  int   n;

  always #5 clk = ~clk;

  nanomamba_pwr_seq #(
    .NUM_EXP(NE), .TIMER_W(20), .WAKE_W(8), .GATE_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .vad_trigger(vad_trigger), .frame_done(frame_done), .logits_valid(logits_valid),
    .gate_w(gate_w), .cfg_gate_thr(cfg_gate_thr), .cfg_force_all(cfg_force_all),
    .cfg_frame_cycles(cfg_frame_cycles), .cfg_wake_cycles(cfg_wake_cycles),
    .status_busy(status_busy), .status_done(status_done), .pwr_state(pwr_state),
    .overrun_cnt(overrun_cnt), .clk_en_stft(clk_en_stft), .clk_en_ssm(clk_en_ssm),
    .clk_en_exp(clk_en_exp), .clk_stft(clk_stft), .clk_ssm(clk_ssm), .clk_exp(clk_exp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_en(input string name, input logic stft, input logic ssm,
                          input logic [3:0] ex);
    check({name, "_stft"}, 32'(clk_en_stft), 32'(stft));
    check({name, "_ssm"},  32'(clk_en_ssm),  32'(ssm));
    check({name, "_exp"},  32'(clk_en_exp),  32'(ex));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tmr++;
  endtask

  task automatic run_while(input logic [2:0] st, input int max, output int cnt);
    cnt = 0;
    while (pwr_state == st && cnt < max) begin
      step();
      cnt++;
    end
  endtask

  // Drives one frame_done from STFT and follows the ramp into COMPUTE.
  task automatic ramp_frame(input int vi);
    vec_t v;
    sb_t  e;
    logic [3:0] rem, acc, low;
    int k;
    v = vecs[vi];
    gate_w        = v.gw;
    cfg_gate_thr  = v.thr;
    cfg_force_all = v.force_all;
    check("pre_ramp_state", 32'(pwr_state), 32'(c_ST_STFT));
    frame_done = 1'b1;
    sb_q.push_back('{mask: v.mask, lat: 1 + $countones(v.mask)});
    step();
    frame_done = 1'b0;
    rem = v.mask;
    acc = 4'b0;
    k = 0;
    while (pwr_state == c_ST_RAMP && k < 20) begin
      if (k == 0) begin
        check("ramp_first_ssm", 32'({clk_en_ssm, clk_en_exp}), 32'({1'b1, 4'b0000}));
      end else begin
        low = rem & (~rem + 4'd1);
        acc = acc | low;
        rem = rem & ~low;
        check($sformatf("ramp_order_v%0d_c%0d", vi, k), 32'(clk_en_exp), 32'(acc));
      end
      k++;
      step();
    end
    e = sb_q.pop_front();
    check($sformatf("ramp_latency_v%0d", vi), 32'(k), 32'(e.lat));
    check("compute_state", 32'(pwr_state), 32'(c_ST_COMPUTE));
    check($sformatf("compute_mask_v%0d", vi), 32'(clk_en_exp), 32'(e.mask));
    check("compute_ssm", 32'(clk_en_ssm), 32'd1);
  endtask

  task automatic finish_frame();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    run_while(c_ST_INTER, 300, n);
    check("frame_return_stft", 32'(pwr_state), 32'(c_ST_STFT));
    tmr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expert i weight sits at gate_w[8*i +: 8]; mask bit i is expert i.
    vecs[0] = '{32'hDC32C80A, 8'd128, 1'b0, 4'b1010};
    vecs[1] = '{32'h08070605, 8'd128, 1'b0, 4'b1111};
    vecs[2] = '{32'h08070605, 8'd128, 1'b1, 4'b1111};
    vecs[3] = '{32'hFF007F80, 8'h80,  1'b0, 4'b1001};
    vecs[4] = '{32'h00000000, 8'h00,  1'b0, 4'b1111};
    vecs[5] = '{32'hFEFEFEFF, 8'hFF,  1'b0, 4'b0001};
    vecs[6] = '{32'h807F7F7F, 8'h80,  1'b0, 4'b1000};
    vecs[7] = '{32'hDC32C80A, 8'd128, 1'b1, 4'b1111};

    rst_n = 1'b0;
    ctrl_start = 1'b0; ctrl_stop = 1'b0; vad_trigger = 1'b0;
    frame_done = 1'b0; logits_valid = 1'b0;
    gate_w = 32'h0; cfg_gate_thr = 8'd128; cfg_force_all = 1'b0;
    cfg_frame_cycles = 20'd30; cfg_wake_cycles = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(pwr_state), 32'(c_ST_DEEP_SLEEP));
    check_en("rst", 1'b0, 1'b0, 4'b0);
    check("rst_busy", 32'(status_busy), 32'd0);
    check("rst_done", 32'(status_done), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_state", 32'(pwr_state), 32'(c_ST_DEEP_SLEEP));

    vad_trigger = 1'b1;
    step();
    vad_trigger = 1'b0;
    check("wake_state", 32'(pwr_state), 32'(c_ST_WAKE));
    check("wake_busy", 32'(status_busy), 32'd1);
    check("wake_en_stft", 32'(clk_en_stft), 32'd1);
    run_while(c_ST_WAKE, 20, n);
    check("wake_cycles_3", 32'(n), 32'd4);
    check("stft_state", 32'(pwr_state), 32'(c_ST_STFT));
    check_en("stft", 1'b1, 1'b0, 4'b0);
    tmr = 0;

    for (int i = 0; i < 8; i++) begin
      ramp_frame(i);
      finish_frame();
    end

    // Frame pacing and overrun boundaries at a 100-cycle period.
    cfg_frame_cycles = 20'd100;
    ramp_frame(0);
    while (tmr < 40) step();
    check("c40_state", 32'(pwr_state), 32'(c_ST_COMPUTE));
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("inter_state", 32'(pwr_state), 32'(c_ST_INTER));
    check_en("inter", 1'b0, 1'b0, 4'b0);
    run_while(c_ST_INTER, 200, n);
    check("inter_exit_tmr", 32'(tmr), 32'd100);
    check("inter_to_stft", 32'(pwr_state), 32'(c_ST_STFT));
    check("reentry_en_stft", 32'(clk_en_stft), 32'd1);
    tmr = 0;

    ramp_frame(0);
    while (tmr < 98) step();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("c98_inter", 32'(pwr_state), 32'(c_ST_INTER));
    step();
    check("c98_stft", 32'(pwr_state), 32'(c_ST_STFT));
    check("c98_ovr", 32'(overrun_cnt), 32'd0);
    tmr = 0;

    ramp_frame(0);
    while (tmr < 99) step();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("c99_stft", 32'(pwr_state), 32'(c_ST_STFT));
    check("c99_ovr", 32'(overrun_cnt), 32'd1);
    tmr = 0;

    ramp_frame(0);
    while (tmr < 120) step();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("c120_stft", 32'(pwr_state), 32'(c_ST_STFT));
    check("c120_ovr", 32'(overrun_cnt), 32'd2);
    check_en("c120", 1'b1, 1'b0, 4'b0);
    tmr = 0;

    // frame_done during RAMP is held and consumed on COMPUTE's first cycle.
    frame_done = 1'b1; step(); step(); frame_done = 1'b0;
    run_while(c_ST_RAMP, 20, n);
    check("pend_compute", 32'(pwr_state), 32'(c_ST_COMPUTE));
    step();
    check("pend_inter", 32'(pwr_state), 32'(c_ST_INTER));
    run_while(c_ST_INTER, 200, n);
    tmr = 0;

    // logits_valid beats an overrunning frame_done.
    ramp_frame(0);
    while (tmr < 110) step();
    logits_valid = 1'b1; frame_done = 1'b1; step();
    logits_valid = 1'b0; frame_done = 1'b0;
    check("done_state", 32'(pwr_state), 32'(c_ST_DONE));
    check("done_flag", 32'(status_done), 32'd1);
    check("done_busy", 32'(status_busy), 32'd0);
    check("done_ovr", 32'(overrun_cnt), 32'd2);
    check("done_ssm_exp", 32'({clk_en_ssm, clk_en_exp}), 32'd0);
    step();
    check("sleep_state", 32'(pwr_state), 32'(c_ST_DEEP_SLEEP));
    check("sleep_done_sticky", 32'(status_done), 32'd1);
    check_en("sleep", 1'b0, 1'b0, 4'b0);

    cfg_wake_cycles = 8'd0;
    ctrl_start = 1'b1; step(); ctrl_start = 1'b0;
    check("rewake_done_clr", 32'(status_done), 32'd0);
    run_while(c_ST_WAKE, 20, n);
    check("wake_cycles_0", 32'(n), 32'd1);
    tmr = 0;
    ramp_frame(0);
    logits_valid = 1'b1; step(); logits_valid = 1'b0;
    check("done2_state", 32'(pwr_state), 32'(c_ST_DONE));
    ctrl_start = 1'b1; step(); ctrl_start = 1'b0;
    check("done_restart_state", 32'(pwr_state), 32'(c_ST_STFT));
    check("done_restart_flag", 32'(status_done), 32'd0);
    check("done_restart_stft", 32'(clk_en_stft), 32'd1);
    tmr = 0;

    // ctrl_stop in RAMP, alone and together with ctrl_start.
    frame_done = 1'b1; step(); frame_done = 1'b0;
    step();
    check("stop_pre_ramp", 32'(pwr_state), 32'(c_ST_RAMP));
    ctrl_stop = 1'b1; step(); ctrl_stop = 1'b0;
    check("stop_state", 32'(pwr_state), 32'(c_ST_DEEP_SLEEP));
    check_en("stop", 1'b0, 1'b0, 4'b0);
    ctrl_start = 1'b1; ctrl_stop = 1'b1; step();
    ctrl_start = 1'b0; ctrl_stop = 1'b0;
    check("startstop_idle", 32'(pwr_state), 32'(c_ST_DEEP_SLEEP));
    ctrl_start = 1'b1; step(); ctrl_start = 1'b0;
    run_while(c_ST_WAKE, 20, n);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("ss_pre_ramp", 32'(pwr_state), 32'(c_ST_RAMP));
    ctrl_start = 1'b1; ctrl_stop = 1'b1; step();
    ctrl_start = 1'b0; ctrl_stop = 1'b0;
    check("ss_state", 32'(pwr_state), 32'(c_ST_DEEP_SLEEP));
    check_en("ss", 1'b0, 1'b0, 4'b0);

    // Overrun counter saturation: every frame overruns with a 1-cycle period.
    cfg_frame_cycles = 20'd1;
    ctrl_start = 1'b1; step(); ctrl_start = 1'b0;
    run_while(c_ST_WAKE, 20, n);
    for (int f = 0; f < 260; f++) begin
      frame_done = 1'b1; step(); frame_done = 1'b0;
      run_while(c_ST_RAMP, 20, n);
      frame_done = 1'b1; step(); frame_done = 1'b0;
    end
    check("ovr_saturate", 32'(overrun_cnt), 32'd255);
    check("ovr_sat_state", 32'(pwr_state), 32'(c_ST_STFT));

    // Asynchronous reset mid-COMPUTE while clk is still high.
    cfg_frame_cycles = 20'd100;
    frame_done = 1'b1; step(); frame_done = 1'b0;
    run_while(c_ST_RAMP, 20, n);
    check("arst_pre_compute", 32'(pwr_state), 32'(c_ST_COMPUTE));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_clk_high", 32'(clk), 32'd1);
    check_en("arst", 1'b0, 1'b0, 4'b0);
    check("arst_state", 32'(pwr_state), 32'(c_ST_DEEP_SLEEP));
    check("arst_ovr", 32'(overrun_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
